golomb_k_search: RTL and testbench
==================================

Name: golomb_k_search

Overview:
- Sequential successor to the combinational temp calculation.
- Latches one context (A, N, RIType, mode) per transaction and forms temp.
- Searches iteratively for the Golomb parameter k = smallest k with (N << k) >= temp.
- Returns k and temp over a valid/ready handshake; sits between the context RAM read stage and the Golomb encoder/decoder, for both regular and run-interruption coding.

Parameters:
- A_LENGTH, 16, width of accumulated-error A.
- N_LENGTH, 7, width of occurrence count N.
- TEMP_LENGTH, A_LENGTH+1, width of temp (A plus N/2 without overflow).
- MODE_LENGTH, 2, width of mode select.
- K_LENGTH, 5, width of k output.
- K_MAX, 16, largest k searched; result saturates here.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  context presented.
- in_ready  out  1  block can accept a context.
- A_Select  in  A_LENGTH  accumulated error of the selected context.
- N_Select  in  N_LENGTH  occurrence count of the selected context.
- RIType  in  1  run-interruption type (0 or 1).
- mode  in  MODE_LENGTH  2'b00 regular, 2'b01 run interruption; others treated as regular.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- temp  out  TEMP_LENGTH  computed temp.
- k  out  K_LENGTH  Golomb parameter.
- k_err  out  1  N_Select was 0, or k saturated at K_MAX with (N << K_MAX) < temp.

Behaviour:
- Reset (async, rst_n=0): state IDLE. in_ready=1, out_valid=0, temp=0, k=0, k_err=0, all internal registers cleared. Reset takes effect immediately, including mid-search; any in-flight context is discarded.
- Accept: in_valid && in_ready at a rising edge.
  - Latch A, N, RIType, mode.
  - Compute temp = A in regular mode; temp = A + (N >> 1) * RIType in run-interruption mode.
  - Width rule: zero-extend to TEMP_LENGTH before adding; no truncation.
- States:
  - IDLE: in_ready=1. On accept -> SEARCH with k_cnt=0.
  - SEARCH: in_ready=0.
    - Each cycle compare (N << k_cnt) against temp. Compare at N_LENGTH+K_MAX bits so the shift never overflows.
    - If >= temp: latch k=k_cnt, go to DONE.
    - Else if k_cnt==K_MAX: k=K_MAX, k_err=1, go to DONE.
    - Else k_cnt+1.
  - DONE: out_valid=1; temp, k and k_err are stable until the handshake.
    - On out_ready: out_valid drops next cycle unless a new context is accepted.
    - in_ready = out_ready in DONE, so a back-to-back accept is allowed: out_ready && in_valid in the same cycle -> SEARCH directly with the new context.
- Latency: result appears k+2 cycles after accept (1 latch cycle, k+1 compare cycles). Worst case K_MAX+2.
- Boundary conditions:
  - temp=0 -> k=0 after the first compare.
  - N=0 -> skip the search, k=0, k_err=1, DONE next cycle.
  - in_valid while busy is ignored; the source must hold it.
  - out_ready asserted with out_valid=0 has no effect.
  - Inputs are sampled only at accept; later changes have no effect.

Optional Feature:
- Macro GOLOMB_K_PARALLEL_EN.
- Defined:
  - SEARCH is replaced by a single-cycle parallel compare of all K_MAX+1 shifted copies followed by a priority encoder.
  - Fixed latency of 2 cycles from accept to out_valid.
  - k and k_err values are identical to the iterative mode.
- Undefined: iterative search as described; minimal area.

Decomposition:
- Shared package/include: A_LENGTH, N_LENGTH, TEMP_LENGTH, MODE_LENGTH, K_LENGTH, K_MAX defaults (`A_length` etc.), mode encodings MODE_REGULAR=2'b00 and MODE_RUN_INT=2'b01, and state encodings IDLE/SEARCH/DONE.
- Sub-module golomb_temp_calc: the combinational temp formation, instantiated once at the input latch.

Test Plan:
- Regular mode, A=100, N=10, RIType=0 -> temp=100, k=4, k_err=0, out_valid 6 cycles after accept (2 in parallel mode).
- Run-interruption mode, A=100, N=10, RIType=1 -> temp=105, k=4. Same context with RIType=0 -> temp=100, k=4.
- A=5, N=10 -> k=0, out_valid 2 cycles after accept. A=0, N=1 -> temp=0, k=0.
- Saturation and error cases:
  - A=65535, N=1 regular -> temp=65535, k=16, k_err=0.
  - A=65535, N=1, run-interruption, RIType=1 -> temp=65535 (N>>1 = 0), k=16.
  - N=0, A=7 -> k=0, k_err=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0. Then out_ready=1 with in_valid=1 -> back-to-back accept, the second result is correct.
- Reset mid-search: assert rst_n=0 during SEARCH of A=1000, N=1 -> outputs zero immediately, in_ready=1. The next transaction computes correctly.

Source files
------------

// File: rtl/golomb_k_search_pkg.sv
`default_nettype none
// ============================================================================
// Module   : golomb_k_search_pkg
// Purpose  : Shared widths, mode/state encodings, the latched context type and
//            small helpers for the Golomb k search block.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package golomb_k_search_pkg;

  localparam int A_LENGTH    = 16;
  localparam int N_LENGTH    = 7;
  localparam int TEMP_LENGTH = A_LENGTH + 1;
  localparam int MODE_LENGTH = 2;
  localparam int K_LENGTH    = 5;
  localparam int K_MAX       = 16;
  // N shifted by up to K_MAX never loses bits at this width.
  localparam int CMP_LENGTH  = N_LENGTH + K_MAX;

  localparam logic [MODE_LENGTH-1:0] MODE_REGULAR = 2'b00;
  localparam logic [MODE_LENGTH-1:0] MODE_RUN_INT = 2'b01;

  localparam int STATE_W = 2;
  typedef logic [STATE_W-1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SEARCH = 2'd1;
  localparam state_t ST_DONE   = 2'd2;

  typedef struct packed {
    logic [A_LENGTH-1:0]    a;
    logic [N_LENGTH-1:0]    n;
    logic                   ritype;
    logic [MODE_LENGTH-1:0] mode;
  } ctx_t;

  function automatic logic [CMP_LENGTH-1:0] f_shift_n(
    input logic [N_LENGTH-1:0] n,
    input logic [K_LENGTH-1:0] sh
  );
    return {{K_MAX{1'b0}}, n} << sh;
  endfunction

  function automatic logic [CMP_LENGTH-1:0] f_ext_temp(
    input logic [TEMP_LENGTH-1:0] t
  );
    return {{(CMP_LENGTH-TEMP_LENGTH){1'b0}}, t};
  endfunction

endpackage
`default_nettype wire

// File: rtl/golomb_k_search_if.sv
`default_nettype none
// ============================================================================
// Module   : golomb_k_search_if
// Purpose  : Context-in / result-out handshake bundle of golomb_k_search.
// Signals  : in_valid/in_ready, A_Select, N_Select, RIType, mode (context side)
//            out_valid/out_ready, temp, k, k_err (result side)
// Modports : slave  - the search block
//            master - the context source / result consumer
// Revision : 1.0 - initial release
// ============================================================================
interface golomb_k_search_if;
  import golomb_k_search_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [A_LENGTH-1:0]    A_Select;
  logic [N_LENGTH-1:0]    N_Select;
  logic                   RIType;
  logic [MODE_LENGTH-1:0] mode;
  logic                   out_valid;
  logic                   out_ready;
  logic [TEMP_LENGTH-1:0] temp;
  logic [K_LENGTH-1:0]    k;
  logic                   k_err;

  modport slave (
    input  in_valid, A_Select, N_Select, RIType, mode, out_ready,
    output in_ready, out_valid, temp, k, k_err
  );

  modport master (
    output in_valid, A_Select, N_Select, RIType, mode, out_ready,
    input  in_ready, out_valid, temp, k, k_err
  );

endinterface
`default_nettype wire

// File: rtl/golomb_k_search_temp_calc.sv
`default_nettype none
// ============================================================================
// Module   : golomb_temp_calc
// Purpose  : Combinational temp formation from a latched context.
//            temp = A                      (regular, or any unknown mode)
//            temp = A + (N >> 1) * RIType  (run interruption)
// Ports    : i_a, i_n, i_ritype, i_mode (context) -> o_temp
// Revision : 1.0 - initial release
// ============================================================================
module golomb_temp_calc
  import golomb_k_search_pkg::*;
(
  input  logic [A_LENGTH-1:0]    i_a,
  input  logic [N_LENGTH-1:0]    i_n,
  input  logic                   i_ritype,
  input  logic [MODE_LENGTH-1:0] i_mode,
  output logic [TEMP_LENGTH-1:0] o_temp
);

  logic                   w_add_half;
  logic [TEMP_LENGTH-1:0] w_a_ext;
  logic [TEMP_LENGTH-1:0] w_half_n_ext;

  assign w_add_half   = (i_mode == MODE_RUN_INT) && i_ritype;
  // Both operands zero-extended so the carry lands in the extra temp bit.
  assign w_a_ext      = {1'b0, i_a};
  assign w_half_n_ext = {{(TEMP_LENGTH-N_LENGTH+1){1'b0}}, i_n[N_LENGTH-1:1]};
  assign o_temp       = w_add_half ? (w_a_ext + w_half_n_ext) : w_a_ext;

endmodule
`default_nettype wire

// File: rtl/golomb_k_search.sv
`default_nettype none
// ============================================================================
// Module   : golomb_k_search
// Purpose  : Latches one context, forms temp, and finds the smallest k with
//            (N << k) >= temp (saturating at K_MAX), returning temp/k/k_err
//            over a valid/ready handshake.
// Ports    : clk   - rising-edge clock
//            rst_n - asynchronous active-low reset
//            bus   - golomb_k_search_if.slave (context in, result out)
// Config   : GOLOMB_K_PARALLEL_EN - when defined, all K_MAX+1 shifts are
//            compared in one cycle (fixed 2-cycle latency); otherwise one
//            shift per cycle (k+2 cycle latency).
// Revision : 1.0 - initial release
// ============================================================================
module golomb_k_search
  import golomb_k_search_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  golomb_k_search_if.slave  bus
);

  state_t                 r_state;
  state_t                 w_state_nxt;
  ctx_t                   r_ctx;
  // High during the first SEARCH cycle, while temp is being registered.
  logic                   r_latch;
  logic [TEMP_LENGTH-1:0] r_temp;
  logic [K_LENGTH-1:0]    r_k;
  logic                   r_k_err;

  logic [TEMP_LENGTH-1:0] w_temp;
  logic                   w_accept;
  logic                   w_in_ready;
  logic                   w_out_valid;
  logic                   w_res_valid;
  logic [K_LENGTH-1:0]    w_res_k;
  logic                   w_res_err;

  golomb_temp_calc u_temp_calc (
    .i_a      (r_ctx.a),
    .i_n      (r_ctx.n),
    .i_ritype (r_ctx.ritype),
    .i_mode   (r_ctx.mode),
    .o_temp   (w_temp)
  );

  assign w_accept = bus.in_valid && w_in_ready;

`ifdef GOLOMB_K_PARALLEL_EN
  logic [K_MAX:0] w_ge_vec;

  generate
    for (genvar gi = 0; gi <= K_MAX; gi++) begin : g_par_cmp
      assign w_ge_vec[gi] = f_shift_n(r_ctx.n, K_LENGTH'(gi)) >= f_ext_temp(r_temp);
    end
  endgenerate

  // Priority encoder: lowest passing shift wins; none passing saturates.
  always_comb begin
    w_res_k   = K_LENGTH'(K_MAX);
    w_res_err = 1'b1;
    for (int j = K_MAX; j >= 0; j--) begin
      if (w_ge_vec[j]) begin
        w_res_k   = K_LENGTH'(j);
        w_res_err = 1'b0;
      end
    end
    if (r_ctx.n == '0) begin
      w_res_k   = '0;
      w_res_err = 1'b1;
    end
  end

  assign w_res_valid = !r_latch;
`else
  logic [K_LENGTH-1:0] r_kcnt;
  logic                w_ge;
  logic                w_sat;

  assign w_ge  = f_shift_n(r_ctx.n, r_kcnt) >= f_ext_temp(r_temp);
  assign w_sat = (r_kcnt == K_LENGTH'(K_MAX));

  // The error branch is only taken on the saturated step, so r_kcnt == K_MAX.
  always_comb begin
    w_res_k   = r_kcnt;
    w_res_err = 1'b0;
    if (r_ctx.n == '0) begin
      w_res_k   = '0;
      w_res_err = 1'b1;
    end else if (!w_ge) begin
      w_res_err = 1'b1;
    end
  end

  assign w_res_valid = !r_latch && ((r_ctx.n == '0) || w_ge || w_sat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kcnt <= '0;
    end else if (w_accept) begin
      r_kcnt <= '0;
    end else if ((r_state == ST_SEARCH) && !r_latch && !w_res_valid) begin
      r_kcnt <= r_kcnt + 1'b1;
    end
  end
`endif

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_SEARCH;
      end
      ST_SEARCH: begin
        if (w_res_valid) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (w_accept)           w_state_nxt = ST_SEARCH;
        else if (bus.out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      ST_IDLE: w_in_ready = 1'b1;
      ST_DONE: begin
        // Releasing the result frees the block for a back-to-back accept.
        w_in_ready  = bus.out_ready;
        w_out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctx   <= '0;
      r_latch <= 1'b0;
      r_temp  <= '0;
      r_k     <= '0;
      r_k_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_ctx.a      <= bus.A_Select;
        r_ctx.n      <= bus.N_Select;
        r_ctx.ritype <= bus.RIType;
        r_ctx.mode   <= bus.mode;
        r_latch      <= 1'b1;
      end else if ((r_state == ST_SEARCH) && r_latch) begin
        r_temp  <= w_temp;
        r_latch <= 1'b0;
      end
      if ((r_state == ST_SEARCH) && w_res_valid) begin
        r_k     <= w_res_k;
        r_k_err <= w_res_err;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.temp      = r_temp;
  assign bus.k         = r_k;
  assign bus.k_err     = r_k_err;

endmodule
`default_nettype wire

// File: tb/tb_golomb_k_search.sv
`default_nettype none
// ============================================================================
// Module   : tb_golomb_k_search
// Purpose  : Self-checking bench for golomb_k_search: directed cases with
//            hand-computed results plus randomized traffic compared each
//            cycle against an arithmetic reference model.
// Config   : GOLOMB_K_PARALLEL_EN selects the expected latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_golomb_k_search;
  import golomb_k_search_pkg::*;

`ifdef GOLOMB_K_PARALLEL_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  golomb_k_search_if u_if ();

  golomb_k_search u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain arithmetic straight from the rules.
  function automatic void model(input int a, input int n, input int rit, input int mode,
                                output int temp, output int k, output int err, output int lat);
    temp = a + ((mode == 1 && rit == 1) ? n / 2 : 0);
    k    = K_MAX;
    err  = 1;
    if (n == 0) begin
      k   = 0;
      err = 1;
    end else begin
      for (int j = K_MAX; j >= 0; j--) begin
        if (longint'(n) * (longint'(1) << j) >= longint'(temp)) begin
          k   = j;
          err = 0;
        end
      end
    end
    lat = (PAR || n == 0) ? 2 : k + 2;
  endfunction

  function automatic int lat_of(input int k);
    return PAR ? 2 : k + 2;
  endfunction

  // ------------------------------------------------------ cycle monitor
  // m_st: 0 idle, 1 busy, 2 result held
  initial begin
    int m_st, m_cnt, m_temp, m_k, m_err, m_lat, old;
    logic acc;
    m_st = 0; m_cnt = 0; m_temp = 0; m_k = 0; m_err = 0; m_lat = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_st = 0;
      end else begin
        old = m_st;
        case (old)
          0: begin
            chk("mon_idle_out_valid", u_if.out_valid, 0);
            chk("mon_idle_in_ready", u_if.in_ready, 1);
          end
          1: begin
            chk("mon_busy_out_valid", u_if.out_valid, 0);
            chk("mon_busy_in_ready", u_if.in_ready, 0);
          end
          default: begin
            chk("mon_done_out_valid", u_if.out_valid, 1);
            chk("mon_done_in_ready", u_if.in_ready, u_if.out_ready);
            chk("mon_temp", u_if.temp, m_temp);
            chk("mon_k", u_if.k, m_k);
            chk("mon_k_err", u_if.k_err, m_err);
          end
        endcase
        acc = u_if.in_valid && ((old == 0) || (old == 2 && u_if.out_ready));
        if (old == 1) begin
          m_cnt--;
          if (m_cnt == 0) m_st = 2;
        end else if (old == 2 && u_if.out_ready) begin
          m_st = 0;
        end
        if (acc) begin
          model(int'(u_if.A_Select), int'(u_if.N_Select), int'(u_if.RIType),
                int'(u_if.mode), m_temp, m_k, m_err, m_lat);
          m_st  = 1;
          m_cnt = m_lat;
        end
      end
    end
  end

  // ---------------------------------------------------------- stimulus
  task automatic present(input int a, input int n, input int rit, input int mode);
    u_if.A_Select = A_LENGTH'(a);
    u_if.N_Select = N_LENGTH'(n);
    u_if.RIType   = rit[0];
    u_if.mode     = MODE_LENGTH'(mode);
  endtask

  task automatic scramble();
    present(int'($urandom), int'($urandom), int'($urandom), int'($urandom));
  endtask

  // Called just after a rising edge; returns just after the accept edge.
  task automatic accept(input int a, input int n, input int rit, input int mode);
    int g;
    present(a, n, rit, mode);
    u_if.in_valid = 1'b1;
    g = 0;
    @(negedge clk);
    while (!u_if.in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) chk("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    u_if.in_valid = 1'b0;
    scramble();
  endtask

  // Called just after the accept edge; returns at the negedge showing out_valid.
  task automatic wait_result(input string tag, input int et, input int ek, input int ee, input int elat);
    int c;
    c = 0;
    @(negedge clk);
    while (!u_if.out_valid && c < 40) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_latency"}, c, elat);
    chk({tag, "_temp"}, u_if.temp, et);
    chk({tag, "_k"}, u_if.k, ek);
    chk({tag, "_k_err"}, u_if.k_err, ee);
  endtask

  task automatic txn(input string tag, input int a, input int n, input int rit, input int mode,
                     input int et, input int ek, input int ee, input int elat);
    accept(a, n, rit, mode);
    wait_result(tag, et, ek, ee, elat);
    @(posedge clk);
    #1;
  endtask

  function automatic int rand_a();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 15));
      1:       return int'($urandom_range(0, 65535));
      2:       return int'($urandom_range(65500, 65535));
      default: return int'($urandom_range(0, 2000));
    endcase
  endfunction

  function automatic int rand_n();
    case ($urandom_range(0, 7))
      0:       return 0;
      1:       return 1;
      default: return int'($urandom_range(0, 127));
    endcase
  endfunction

  initial begin
    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b1;
    present(0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", u_if.out_valid, 0);
    chk("rst_in_ready", u_if.in_ready, 1);
    chk("rst_temp", u_if.temp, 0);
    chk("rst_k", u_if.k, 0);
    chk("rst_k_err", u_if.k_err, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    txn("reg_100_10", 100, 10, 0, 0, 100, 4, 0, lat_of(4));
    txn("ri_100_10_r1", 100, 10, 1, 1, 105, 4, 0, lat_of(4));
    txn("ri_100_10_r0", 100, 10, 0, 1, 100, 4, 0, lat_of(4));
    txn("mode2_as_regular", 100, 10, 1, 2, 100, 4, 0, lat_of(4));
    txn("a5_n10", 5, 10, 0, 0, 5, 0, 0, 2);
    txn("a0_n1", 0, 1, 0, 0, 0, 0, 0, 2);
    txn("sat_reg", 65535, 1, 0, 0, 65535, 16, 0, lat_of(16));
    txn("sat_ri", 65535, 1, 1, 1, 65535, 16, 0, lat_of(16));
    txn("n_zero", 7, 0, 0, 0, 7, 0, 1, 2);

    // Backpressure, then a back-to-back accept on the releasing edge.
    u_if.out_ready = 1'b0;
    accept(300, 3, 1, 1);
    wait_result("bp_first", 301, 7, 0, lat_of(7));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_in_ready", u_if.in_ready, 0);
      chk("bp_out_valid", u_if.out_valid, 1);
      chk("bp_temp", u_if.temp, 301);
      chk("bp_k", u_if.k, 7);
    end
    @(posedge clk);
    #1;
    u_if.out_ready = 1'b1;
    accept(2000, 5, 0, 0);
    wait_result("b2b_second", 2000, 9, 0, lat_of(9));
    @(posedge clk);
    #1;

    // Reset in the middle of a search.
    accept(1000, 1, 0, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", u_if.out_valid, 0);
    chk("midrst_in_ready", u_if.in_ready, 1);
    chk("midrst_temp", u_if.temp, 0);
    chk("midrst_k", u_if.k, 0);
    chk("midrst_k_err", u_if.k_err, 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    txn("after_rst", 1000, 1, 0, 0, 1000, 10, 0, lat_of(10));

    // Randomized traffic; the monitor checks every cycle.
    for (int i = 0; i < 800; i++) begin
      u_if.in_valid  = ($urandom_range(0, 1) == 1);
      u_if.out_ready = ($urandom_range(0, 3) != 0);
      present(rand_a(), rand_n(), int'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      @(posedge clk);
      #1;
    end
    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b1;
    repeat (30) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
